pc_sequencer: RTL

Next-PC controller for the RISC-V core. It owns the program-counter register and sequences instruction fetch through a req/ack handshake with instruction memory. Each cycle it selects the next PC from sequential increment, branch, jump, trap entry or trap return. `pc_out` feeds the `Pc` register input path and the fetch address bus.

---
 rtl/pc_sequencer_if.sv | 31 +++
 rtl/pc_sequencer.sv | 116 +++++++++++
 2 files changed

// File: rtl/pc_sequencer_if.sv
// Fetch/redirect bundle between the next-PC sequencer and the rest of the core.
// The sequencer takes the master side.
interface pc_sequencer_if;
  logic        fetch_ack;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        trap;
  logic        trap_ret;
  logic        halt;
  logic [31:0] pc_out;
  logic        fetch_req;
  logic [31:0] epc;
  logic [1:0]  trap_cause;
  logic [31:0] fetch_count;
  logic        halted;

  modport master (
    input  fetch_ack, stall, branch_taken, branch_target, jump, jump_target,
           trap, trap_ret, halt,
    output pc_out, fetch_req, epc, trap_cause, fetch_count, halted
  );

  modport slave (
    output fetch_ack, stall, branch_taken, branch_target, jump, jump_target,
           trap, trap_ret, halt,
    input  pc_out, fetch_req, epc, trap_cause, fetch_count, halted
  );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC controller: owns the PC, drives the fetch req/ack handshake and resolves
// trap, trap return, jump and branch redirects in fixed priority order.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input logic            clk,
  input logic            rst,
  pc_sequencer_if.master bus
);

  typedef enum logic [1:0] {StRst, StFetch, StFlush, StHalt} state_e;

  localparam logic [1:0] CauseNone      = 2'd0;
  localparam logic [1:0] CauseTrap      = 2'd1;
  localparam logic [1:0] CauseMisalign  = 2'd2;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] count_q, count_d;
  logic        req_q;
  logic        halted_q;

  logic        redirect;
  logic [31:0] target;

  // Non-trap redirect target, already priority-resolved among trap_ret/jump/branch.
  always_comb begin
    redirect = 1'b0;
    target   = pc_q;
    if (bus.trap_ret) begin
      redirect = 1'b1;
      target   = epc_q;
    end else if (bus.jump) begin
      redirect = 1'b1;
      target   = bus.jump_target;
    end else if (bus.branch_taken) begin
      redirect = 1'b1;
      target   = bus.branch_target;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    count_d = count_q;
    unique case (state_q)
      StRst: begin
        state_d = StFetch;
      end
      StFetch: begin
        if (bus.trap) begin
          epc_d   = pc_q;
          cause_d = CauseTrap;
          pc_d    = TRAP_VECTOR;
          state_d = StFlush;
        end else if (redirect) begin
          if (target[1:0] != 2'b00) begin
            epc_d   = target;
            cause_d = CauseMisalign;
            pc_d    = TRAP_VECTOR;
          end else begin
            pc_d    = target;
          end
          state_d = StFlush;
        end else if (bus.halt) begin
          state_d = StHalt;
        end else if (bus.fetch_ack && !bus.stall) begin
          pc_d    = pc_q + 32'd4;
          count_d = count_q + 32'd1;
        end
      end
      StFlush: begin
        state_d = StFetch;
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StRst;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StRst;
      pc_q     <= RESET_VECTOR;
      epc_q    <= 32'd0;
      cause_q  <= CauseNone;
      count_q  <= 32'd0;
      req_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      epc_q    <= epc_d;
      cause_q  <= cause_d;
      count_q  <= count_d;
      req_q    <= (state_d == StFetch);
      halted_q <= (state_d == StHalt);
    end
  end

  assign bus.pc_out      = pc_q;
  assign bus.fetch_req   = req_q;
  assign bus.epc         = epc_q;
  assign bus.trap_cause  = cause_q;
  assign bus.fetch_count = count_q;
  assign bus.halted      = halted_q;

endmodule
